pll_cmd_sequencer: RTL

PLL_CMD_SEQUENCER -- requirements
Module: pll_cmd_sequencer

---
 rtl/pll_ctrl_pkg.sv | 28 ++
 rtl/pll_tx_serializer.sv | 48 ++++
 rtl/pll_cmd_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared constants and encodings for the PLL control path: command modes,
// sequencer states and the word/segment geometry of a MASH configuration word.
package pll_ctrl_pkg;

   localparam int SEG_W  = 12;
   localparam int WORD_W = 43;
   localparam int NREG   = 4;

   typedef enum logic [1:0] {
      MODE_CONT = 2'b00,
      MODE_WR   = 2'b01,
      MODE_RD   = 2'b10,
      MODE_IDLE = 2'b11
   } mode_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACC      = 3'd1,
      ST_COMMIT   = 3'd2,
      ST_RD_FETCH = 3'd3,
      ST_RD_SEND  = 3'd4,
      ST_CONT     = 3'd5
   } state_t;

   // Leading tag bits of every readback frame toward the MISO FIFO.
   localparam logic [1:0] FRAME_TAG = 2'b10;

endpackage

// File: rtl/pll_tx_serializer.sv
// Splits one register-bank word into four tagged 16-bit readback frames,
// handed out one per valid/ready handshake.
module pll_tx_serializer #(
   parameter int SEG_W  = pll_ctrl_pkg::SEG_W,
   parameter int WORD_W = pll_ctrl_pkg::WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [WORD_W-1:0] i_word,
   input  logic              i_tx_ready,
   output logic              o_tx_valid,
   output logic [15:0]       o_tx_data,
   output logic              o_done
);
   import pll_ctrl_pkg::*;

   logic [WORD_W-1:0] r_word;
   logic [1:0]        r_k;
   logic              r_valid;
   logic              w_accept;

   assign w_accept   = r_valid & i_tx_ready;
   assign o_tx_valid = r_valid;
   assign o_done     = w_accept & (r_k == 2'd3);
   // The word shifts down one segment per frame, so the short top segment
   // arrives zero-extended without any special case.
   assign o_tx_data  = r_valid ? {FRAME_TAG, r_k, r_word[SEG_W-1:0]} : 16'h0000;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_word  <= '0;
         r_k     <= 2'd0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_word  <= i_word;
         r_k     <= 2'd0;
         r_valid <= 1'b1;
      end else if (w_accept) begin
         r_word <= r_word >> SEG_W;
         r_k    <= r_k + 2'd1;
         if (r_k == 2'd3) r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pll_cmd_sequencer.sv
// Decodes SPI command words into register-bank writes, readback frames and
// continuous MASH output selection.
module pll_cmd_sequencer #(
   parameter int SEG_W  = pll_ctrl_pkg::SEG_W,
   parameter int WORD_W = pll_ctrl_pkg::WORD_W,
   parameter int NREG   = pll_ctrl_pkg::NREG
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   input  logic [15:0]             cmd_data,
   output logic                    cmd_ready,
   input  logic                    tick,
   output logic                    wr_en,
   output logic [$clog2(NREG)-1:0] wr_addr,
   output logic [WORD_W-1:0]       wr_data,
   output logic [$clog2(NREG)-1:0] rd_addr,
   input  logic [WORD_W-1:0]       rd_data,
   output logic                    tx_valid,
   output logic [15:0]             tx_data,
   input  logic                    tx_ready,
   output logic                    cont_en,
   output logic [$clog2(NREG)-1:0] cont_addr,
   output logic                    err
);
   import pll_ctrl_pkg::*;

   localparam int AW     = $clog2(NREG);
   localparam int LAST_W = WORD_W - 3 * SEG_W;

   state_t             r_state;
   logic [1:0]         r_seg_cnt;
   logic [AW-1:0]      r_addr;
   logic [3*SEG_W-1:0] r_word;
   logic               r_wr_en;
   logic [AW-1:0]      r_wr_addr;
   logic [WORD_W-1:0]  r_wr_data;
   logic [AW-1:0]      r_rd_addr;
   logic               r_cont_en;
   logic [AW-1:0]      r_cont_addr;
   logic               r_err;

   logic               w_acc;
   mode_t              w_mode;
   logic [AW-1:0]      w_addr;
   logic [SEG_W-1:0]   w_pay;
   logic               w_tx_done;

   // Held low during reset so the FIFO never sees a handshake mid-reset.
   assign cmd_ready = rst & (r_state inside {ST_IDLE, ST_ACC, ST_CONT});
   assign w_acc     = cmd_valid & cmd_ready;
   assign w_mode    = mode_t'(cmd_data[15:14]);
   assign w_addr    = cmd_data[13:12];
   assign w_pay     = cmd_data[SEG_W-1:0];

   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign rd_addr   = r_rd_addr;
   assign cont_en   = r_cont_en;
   assign cont_addr = r_cont_addr;
   assign err       = r_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_seg_cnt   <= 2'd0;
         r_addr      <= '0;
         r_word      <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_rd_addr   <= '0;
         r_cont_en   <= 1'b0;
         r_cont_addr <= '0;
         r_err       <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            ST_COMMIT:   r_state <= ST_IDLE;
            ST_RD_FETCH: r_state <= ST_RD_SEND;
            ST_RD_SEND:  if (w_tx_done) r_state <= ST_IDLE;
            default: begin
               if (w_acc && r_state == ST_ACC && w_mode == MODE_WR) begin
                  if (w_addr != r_addr) begin
                     r_err     <= 1'b1;
                     r_word    <= '0;
                     r_seg_cnt <= 2'd0;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_seg_cnt <= r_seg_cnt + 2'd1;
                     case (r_seg_cnt)
                        2'd1: r_word[2*SEG_W-1:SEG_W]   <= w_pay;
                        2'd2: r_word[3*SEG_W-1:2*SEG_W] <= w_pay;
                        default: begin
                           r_wr_data <= {w_pay[LAST_W-1:0], r_word};
                           r_wr_addr <= r_addr;
                           r_wr_en   <= 1'b1;
                           r_word    <= '0;
                           r_state   <= ST_COMMIT;
                        end
                     endcase
                  end
               end else if (w_acc) begin
                  // A non-write breaks a write in progress; the command
                  // itself still runs below, so an idle here ends with err=0.
                  if (r_state == ST_ACC) begin
                     r_err     <= 1'b1;
                     r_word    <= '0;
                     r_seg_cnt <= 2'd0;
                  end
                  case (w_mode)
                     MODE_WR: begin
                        r_addr    <= w_addr;
                        r_word    <= {{(2*SEG_W){1'b0}}, w_pay};
                        r_seg_cnt <= 2'd1;
                        r_cont_en <= 1'b0;
                        r_state   <= ST_ACC;
                     end
                     MODE_RD: begin
                        r_rd_addr <= w_addr;
                        r_cont_en <= 1'b0;
                        r_state   <= ST_RD_FETCH;
                     end
                     MODE_IDLE: begin
                        r_cont_en <= 1'b0;
                        r_err     <= 1'b0;
                        r_state   <= ST_IDLE;
                     end
                     default: begin
                        r_cont_addr <= w_addr;
                        r_cont_en   <= 1'b1;
                        r_state     <= ST_CONT;
                     end
                  endcase
               end else if (r_state == ST_CONT && tick) begin
                  r_cont_addr <= r_cont_addr + 1'b1;
               end
            end
         endcase
      end
   end

   pll_tx_serializer #(
      .SEG_W  (SEG_W),
      .WORD_W (WORD_W)
   ) u_tx (
      .clk        (clk),
      .rst        (rst),
      .i_load     (r_state == ST_RD_FETCH),
      .i_word     (rd_data),
      .i_tx_ready (tx_ready),
      .o_tx_valid (tx_valid),
      .o_tx_data  (tx_data),
      .o_done     (w_tx_done)
   );

endmodule
